mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage between execute and the data-memory bus. Accepts one
//  RV32I memory op at a time, runs a req/ack bus transaction, aligns and
//  extends load data, and returns it to the register file's secondary write
//  port (rdmau/rdmau_en/data_mau_in). Flags misaligned, illegal and timed-out
//  accesses; exports the pending load destination for hazard/stall logic.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req waits for mem_ack; 0 = no timeout
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high reset
//  req_valid      in   1   execute presents a memory op
//  req_ready      out  1   unit can accept (high only in IDLE)
//  req_store      in   1   1 = store, 0 = load
//  req_funct3     in   3   RV32I funct3: 000 B,001 H,010 W,100 BU,101 HU
//  req_addr       in   32  effective byte address
//  req_wdata      in   32  store data (rs2)
//  req_rd         in   5   load destination register
//  mem_req        out  1   bus request, held until ack or timeout
//  mem_we         out  1   bus write enable
//  mem_be         out  4   byte lane enables
//  mem_addr       out  32  word address {req_addr[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_ack        in   1   bus completes the transfer this cycle
//  mem_rdata      in   32  read data, valid with mem_ack
//  rdmau          out  5   writeback register index
//  rdmau_en       out  1   writeback strobe, one-cycle pulse
//  data_mau_in    out  32  aligned, extended load data
//  pend_valid     out  1   load in flight with rd!=0
//  pend_rd        out  5   destination of in-flight load
//  err_valid      out  1   one-cycle error pulse
//  err_code       out  2   01 misaligned, 10 illegal funct3, 11 timeout
//  err_addr       out  32  req_addr of the faulting op
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: state IDLE, every output 0, timeout counter 0; reset mid-transaction
//   abandons it: mem_req low after the reset edge, no writeback, no error.
//  FSM IDLE -> BUS -> (WB if load) -> IDLE. req_ready = (state==IDLE).
//  IDLE: on req_valid&req_ready latch op. Illegal funct3 (011/110/111, or
//   BU/HU with store) -> err 10; misaligned (H/HU addr[0]!=0, W addr[1:0]!=0)
//   -> err 11? no: err 01. Error cases: err_valid next cycle, stay IDLE, no bus.
//   Otherwise BUS next cycle.
//  BUS: mem_req=1; addr/we/be/wdata stable until exit. be: B=4'b0001<<a[1:0],
//   H=4'b0011<<{a[1],1'b0}, W=4'b1111. wdata: B {4{d[7:0]}}, H {2{d[15:0]}}.
//   mem_ack sampled high -> store: IDLE; load: capture lane, sign (B/H) or
//   zero (BU/HU) extend, go WB. Counter counts BUS cycles; reaching
//   TIMEOUT_CYCLES without ack -> mem_req drops, err 11, IDLE.
//   Ack on the same cycle the counter expires: ack wins.
//  WB: rdmau_en=1 exactly one cycle with rdmau=rd, data_mau_in=value;
//   rd==0 -> rdmau_en stays 0. rdmau/data_mau_in hold last value otherwise.
//  Latency: accept at N -> mem_req at N+1; ack at M -> rdmau_en at M+1.
//   Zero-wait bus: load accept to writeback = 2 cycles; next accept at M+2.
//  pend_valid high from accept through WB cycle inclusive (loads, rd!=0);
//   stall logic must keep the primary rd port off pend_rd during WB, as
//   the register file gives the primary port priority on collision.
// STRUCTURE
//  Package mau_pkg: funct3 localparams, FSM state encoding, err_code values.
//  Sub-module mau_lane_align: combinational be/wdata generation and load lane
//   extract + extend; FSM, counter and output registers stay in top.
// TESTING
//  LW a=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_be=1111,
//   rdmau_en pulse 1 cycle after ack, data_mau_in=0xDEADBEEF.
//  LB a=0x103, rdata=0x80xxxxxx -> be=1000, data=0xFFFFFF80; LBU -> 0x00000080.
//  SH a=0x202, wdata=0x1234ABCD -> be=1100, mem_wdata=0xABCDABCD, we=1, no WB.
//  LW a=0x101 -> err_valid, err_code=01, err_addr=0x101, mem_req never high.
//  TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, err_code=11, ready again.
//  Reset asserted in BUS, and LW rd=0 -> mem_req low next edge; no rdmau_en.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: funct3 values, FSM states,
// error codes and the op-legality helpers used when an op is accepted.
package mau_pkg;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrIllegal    = 2'b10;
  localparam logic [1:0] ErrTimeout    = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StWb   = 2'b10
  } mau_state_e;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
    logic ill;
    case (f3)
      F3Byte, F3Half, F3Word: ill = 1'b0;
      F3ByteU, F3HalfU:       ill = store;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane logic: store lane enables and data replication,
// plus load lane extraction with sign or zero extension.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = wdata_i;
    load_data_o = rdata_i;
    byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: be_o = 4'b1111;
    endcase

    case (funct3_i)
      F3Byte:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3Half:  load_data_o = {{16{half_sel[15]}}, half_sel};
      F3ByteU: load_data_o = {24'h000000, byte_sel};
      F3HalfU: load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: accepts one RV32I memory op, runs a req/ack bus transfer
// with timeout, and writes aligned load data to the register file's second port.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rdmau,
  output logic        rdmau_en,
  output logic [31:0] data_mau_in,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  mau_state_e state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      rdmau_q, rdmau_d;
  logic            rdmau_en_q, rdmau_en_d;
  logic [31:0]     data_q, data_d;
  logic            err_valid_q, err_valid_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [3:0]  be_al;
  logic [31:0] wdata_al;
  logic [31:0] load_al;
  logic        in_bus;

  mau_lane_align u_lane_align (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .be_o        (be_al),
    .wdata_o     (wdata_al),
    .load_data_o (load_al)
  );

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    rdmau_d     = rdmau_q;
    rdmau_en_d  = 1'b0;
    data_d      = data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          cnt_d   = '0;
          if (f3_illegal(req_funct3, req_store)) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrIllegal;
            err_addr_d  = req_addr;
          end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrMisaligned;
            err_addr_d  = req_addr;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // An ack in the expiring cycle still completes the transfer.
        if (mem_ack) begin
          if (store_q) begin
            state_d = StIdle;
          end else begin
            state_d = StWb;
            if (rd_q != 5'd0) begin
              rdmau_en_d = 1'b1;
              rdmau_d    = rd_q;
              data_d     = load_al;
            end
          end
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          state_d     = StIdle;
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
          err_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      rdmau_q     <= 5'd0;
      rdmau_en_q  <= 1'b0;
      data_q      <= 32'h0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rdmau_q     <= rdmau_d;
      rdmau_en_q  <= rdmau_en_d;
      data_q      <= data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Bus outputs are forced to zero outside the transfer so idle/reset reads clean.
  assign in_bus      = (state_q == StBus);
  assign req_ready   = (state_q == StIdle) && !reset;
  assign mem_req     = in_bus;
  assign mem_we      = in_bus && store_q;
  assign mem_be      = in_bus ? be_al : 4'b0000;
  assign mem_addr    = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata   = in_bus ? wdata_al : 32'h0;
  assign rdmau       = rdmau_q;
  assign rdmau_en    = rdmau_en_q;
  assign data_mau_in = data_q;
  assign pend_valid  = (in_bus || (state_q == StWb)) && !store_q && (rd_q != 5'd0);
  assign pend_rd     = pend_valid ? rd_q : 5'd0;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: a driver pushes expected bus,
// writeback and error events; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [4:0]  rdmau;
  logic        rdmau_en;
  logic [31:0] data_mau_in;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rdmau       (rdmau),
    .rdmau_en    (rdmau_en),
    .data_mau_in (data_mau_in),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_addr    (err_addr)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pend;
    logic [4:0]  rd;
    int          cycles;
  } bus_exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  typedef struct {
    logic [1:0]  code;
    logic [31:0] addr;
  } err_exp_t;

  bus_exp_t exp_bus[$];
  wb_exp_t  exp_wb[$];
  err_exp_t exp_err[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event seen/missing, expected otherwise", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
    logic [31:0] b, h;
    b = (rdat >> ((a % 4) * 8)) & 32'hFF;
    h = (rdat >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4:       return b;
      5:       return h;
      default: return rdat;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int f3, input logic [31:0] a);
    case (f3 % 4)
      0:       return 4'(1 << (a % 4));
      1:       return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
    case (f3 % 4)
      0:       return (d & 32'hFF) * 32'h01010101;
      1:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic do_op(input bit store, input int f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input int dly,
                       input logic [31:0] rdat, input bit abort);
    bit illegal, misal;
    int n;
    illegal = (f3 == 3 || f3 == 6 || f3 == 7) || (store && f3 >= 4);
    misal = !illegal && (((f3 == 1 || f3 == 5) && (a % 2) != 0) || (f3 == 2 && (a % 4) != 0));
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      fail("ready_wait");
      return;
    end
    if (illegal) exp_err.push_back('{code: 2'b10, addr: a});
    else if (misal) exp_err.push_back('{code: 2'b01, addr: a});
    else begin
      exp_bus.push_back('{we: store, be: ref_be(f3, a), addr: a & 32'hFFFFFFFC,
                          wdata: ref_wdata(f3, d), pend: !store && rd != 0, rd: rd,
                          cycles: (dly < int'(TO)) ? dly + 1 : int'(TO)});
      if (!abort) begin
        if (dly >= int'(TO)) exp_err.push_back('{code: 2'b11, addr: a});
        else if (!store && rd != 0) exp_wb.push_back('{rd: rd, data: ref_load(f3, a, rdat)});
      end
    end
    req_valid  = 1'b1;
    req_store  = store;
    req_funct3 = 3'(f3);
    req_addr   = a;
    req_wdata  = d;
    req_rd     = rd;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (illegal || misal) begin
      check("err_latency", 128'(err_valid), 128'(1));
      return;
    end
    check("req_latency", 128'(mem_req), 128'(1));
    if (abort) begin
      tick();
      exp_bus.delete();
      exp_wb.delete();
      exp_err.delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_abort_outs", 128'({mem_req, rdmau_en, err_valid, pend_valid}), 128'(0));
      return;
    end
    if (dly < int'(TO)) begin
      repeat (dly) tick();
      mem_ack   = 1'b1;
      mem_rdata = rdat;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end else begin
      n = 0;
      while (mem_req && n < int'(TO) + 5) begin
        tick();
        n++;
      end
      if (mem_req) fail("timeout_wait");
    end
  endtask

  // Monitor: compares every presented output against the queued expectations.
  initial begin : monitor
    int req_cycles;
    bit prev_req, prev_ack;
    bus_exp_t e;
    wb_exp_t w;
    err_exp_t r;
    req_cycles = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_cycles = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        continue;
      end
      if (mem_req) begin
        if (exp_bus.size() == 0) fail("unexpected_mem_req");
        else begin
          e = exp_bus[0];
          check("bus_ctrl", 128'({mem_we, mem_be, mem_addr}), 128'({e.we, e.be, e.addr}));
          if (e.we) check("bus_wdata", 128'(mem_wdata), 128'(e.wdata));
          check("pend_bus", 128'({pend_valid, pend_rd}), 128'({e.pend, e.pend ? e.rd : 5'd0}));
        end
        req_cycles++;
      end else if (prev_req) begin
        if (exp_bus.size() != 0) begin
          check("req_cycles", 128'(req_cycles), 128'(exp_bus[0].cycles));
          void'(exp_bus.pop_front());
        end
        req_cycles = 0;
      end
      if (rdmau_en) begin
        check("wb_latency", 128'(prev_ack), 128'(1));
        if (exp_wb.size() == 0) fail("unexpected_wb");
        else begin
          w = exp_wb.pop_front();
          check("wb_data", 128'({rdmau, data_mau_in}), 128'({w.rd, w.data}));
          check("pend_wb", 128'({pend_valid, pend_rd}), 128'({1'b1, w.rd}));
        end
      end
      if (err_valid) begin
        if (exp_err.size() == 0) fail("unexpected_err");
        else begin
          r = exp_err.pop_front();
          check("err", 128'({err_code, err_addr}), 128'({r.code, r.addr}));
        end
      end
      prev_req = mem_req;
      prev_ack = mem_req && mem_ack;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f3, dly;
    logic [31:0] a;
    repeat (3) tick();
    check("rst_ready", 128'(req_ready), 128'(0));
    check("rst_outs", 128'({mem_req, mem_we, mem_be, mem_addr, rdmau_en, err_valid,
                            pend_valid, pend_rd}), 128'(0));
    reset = 1'b0;
    tick();
    check("ready_after_rst", 128'(req_ready), 128'(1));

    do_op(1'b0, 2, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 0, 32'h103, 32'h0, 5'd6, 0, 32'h80123456, 1'b0);
    do_op(1'b0, 4, 32'h103, 32'h0, 5'd7, 1, 32'h80123456, 1'b0);
    do_op(1'b1, 1, 32'h202, 32'h1234ABCD, 5'd0, 1, 32'h0, 1'b0);
    do_op(1'b0, 2, 32'h101, 32'h0, 5'd8, 0, 32'h0, 1'b0);
    do_op(1'b1, 4, 32'h204, 32'h0, 5'd0, 0, 32'h0, 1'b0);
    do_op(1'b0, 2, 32'h104, 32'h0, 5'd9, 9, 32'h0, 1'b0);
    do_op(1'b0, 2, 32'h108, 32'h0, 5'd10, 9, 32'h0, 1'b1);
    do_op(1'b0, 2, 32'h10C, 32'h0, 5'd0, 1, 32'h55AA55AA, 1'b0);
    do_op(1'b0, 1, 32'h112, 32'h0, 5'd11, 3, 32'hCAFEF00D, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9) < 8) begin
        case ($urandom_range(4))
          0: f3 = 0;
          1: f3 = 1;
          2: f3 = 2;
          3: f3 = 4;
          default: f3 = 5;
        endcase
      end else begin
        f3 = int'($urandom_range(7));
      end
      a = 32'h1000 + ($urandom & 32'hFFF0);
      if ($urandom_range(1) == 1) a = a + 32'($urandom_range(3));
      else if (f3 % 4 == 0) a = a + 32'($urandom_range(3));
      else if (f3 % 4 == 1) a = a + 32'(2 * $urandom_range(1));
      dly = int'($urandom_range(5));
      do_op(1'($urandom_range(1)), f3, a, $urandom, 5'($urandom_range(31)), dly, $urandom,
            1'b0);
    end

    repeat (6) tick();
    check("drain", 128'(exp_bus.size() + exp_wb.size() + exp_err.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
